// File: rtl/pf_pkg.sv
// Shared types and helpers for the pulse stretcher.
package pf_pkg;

  typedef enum logic [1:0] {PST_IDLE, PST_HIGH, PST_GAP} pst_state_t;

  // Effective pulse width: a requested width of 0 still yields one clock.
  function automatic logic [31:0] leff(input logic [31:0] len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/pulse_stretch_if.sv
// Request/configuration inputs and status outputs of the pulse stretcher.
interface pulse_stretch_if #(
  parameter int CNT_W  = 8,
  parameter int PEND_W = 4
) ();

  logic              in;
  logic [CNT_W-1:0]  len;
  logic [CNT_W-1:0]  gap;
  logic              retrig;
  logic              q;
  logic              busy;
  logic [PEND_W-1:0] pend;
  logic              ovf;

  modport master (
    output in, len, gap, retrig,
    input  q, busy, pend, ovf
  );

  modport slave (
    input  in, len, gap, retrig,
    output q, busy, pend, ovf
  );

endinterface

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter: simultaneous inc and dec cancel, increments
// beyond max_lim are dropped and flagged, decrements stop at zero.
module sat_updown_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic [W-1:0] max_lim,
  output logic [W-1:0] q,
  output logic         sat_hit
);

  logic up;
  logic dn;

  // Resolve the net direction and detect a dropped increment.
  always_comb begin
    up      = inc & ~dec;
    dn      = dec & ~inc;
    sat_hit = up & (q >= max_lim);
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (up && !sat_hit) begin
      q <= q + W'(1);
    end else if (dn && q != '0) begin
      q <= q - W'(1);
    end
  end

endmodule

// File: rtl/pulse_stretch.sv
// Pulse stretcher: turns single-clock requests into len-wide pulses spaced
// by at least gap low clocks, queueing or retriggering on overlap.
module pulse_stretch
  import pf_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int PEND_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  pulse_stretch_if.slave  bus
);

  pst_state_t        state;
  pst_state_t        state_d;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_d;
  logic [CNT_W-1:0]  lcnt;
  logic              q_r;
  logic              q_d;
  logic              busy_r;
  logic              ovf_r;
  logic              term;
  logic              pend_nz;
  logic              pend_inc;
  logic              pend_dec;
  logic              sat_hit;
  logic [PEND_W-1:0] pend_lim;
  logic [PEND_W-1:0] pend_q;

  // Pending-request queue; in retrigger mode at most one request is held.
  assign pend_lim = bus.retrig ? PEND_W'(1) : '1;

  sat_updown_cnt #(.W(PEND_W)) u_pend (
    .clk     (clk),
    .rst     (rst),
    .inc     (pend_inc),
    .dec     (pend_dec),
    .max_lim (pend_lim),
    .q       (pend_q),
    .sat_hit (sat_hit)
  );

  // Next state, next counter value and queue controls.
  always_comb begin
    lcnt     = CNT_W'(leff(32'(bus.len)) - 32'd1);
    term     = (cnt == '0);
    pend_nz  = (pend_q != '0);
    state_d  = state;
    cnt_d    = term ? cnt : cnt - CNT_W'(1);
    q_d      = 1'b0;
    pend_inc = 1'b0;
    pend_dec = 1'b0;
    case (state)
      PST_IDLE: begin
        if (bus.in) begin
          state_d = PST_HIGH;
          cnt_d   = lcnt;
          q_d     = 1'b1;
        end
      end
      PST_HIGH: begin
        q_d = 1'b1;
        if (term) begin
          if (bus.gap != '0) begin
            state_d  = PST_GAP;
            cnt_d    = bus.gap - CNT_W'(1);
            q_d      = 1'b0;
            pend_inc = bus.in;
          end else if (pend_nz || bus.in) begin
            cnt_d    = lcnt;
            pend_dec = pend_nz & ~bus.in;
          end else begin
            state_d = PST_IDLE;
            q_d     = 1'b0;
          end
        end else if (bus.in) begin
          if (bus.retrig) begin
            cnt_d = lcnt;
          end else begin
            pend_inc = 1'b1;
          end
        end
      end
      PST_GAP: begin
        if (term) begin
          if (pend_nz || bus.in) begin
            state_d  = PST_HIGH;
            cnt_d    = lcnt;
            q_d      = 1'b1;
            pend_dec = pend_nz & ~bus.in;
          end else begin
            state_d = PST_IDLE;
          end
        end else begin
          pend_inc = bus.in;
        end
      end
      default: begin
        state_d = PST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; ovf is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= PST_IDLE;
      cnt    <= '0;
      q_r    <= 1'b0;
      busy_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      q_r    <= q_d;
      busy_r <= (state_d != PST_IDLE);
      if (sat_hit && !bus.retrig) begin
        ovf_r <= 1'b1;
      end
    end
  end

  assign bus.q    = q_r;
  assign bus.busy = busy_r;
  assign bus.pend = pend_q;
  assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch (PEND_W=2 so overflow is reachable).
module tb_pulse_stretch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  logic [31:0] qtr, btr, ptr;
  int          pmax, nrise;

  pulse_stretch_if #(.CNT_W(8), .PEND_W(2)) bus ();

  pulse_stretch #(.CNT_W(8), .PEND_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bit i of each trace holds the output sampled after clock i of the run.
  task automatic run(input int n, input logic [31:0] ipat,
                     output logic [31:0] qt, output logic [31:0] bt,
                     output logic [31:0] pt, output int pm, output int nr);
    logic qprev;
    qt = '0; bt = '0; pt = '0; pm = 0; nr = 0;
    qprev = bus.q;
    for (int i = 0; i < n; i++) begin
      bus.in = (i < 32) ? ipat[i] : 1'b0;
      tick();
      if (i < 32) begin
        qt[i] = bus.q;
        bt[i] = bus.busy;
        pt[i] = (bus.pend != '0);
      end
      if (int'(bus.pend) > pm) pm = int'(bus.pend);
      if (bus.q && !qprev) nr++;
      qprev = bus.q;
    end
    bus.in = 1'b0;
  endtask

  initial begin
    bus.in = 1'b0; bus.len = 8'd5; bus.gap = 8'd2; bus.retrig = 1'b0;
    rst = 1'b1;
    tick(); tick();
    check("rst_q",    32'(bus.q),    32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_pend", 32'(bus.pend), 32'd0);
    check("rst_ovf",  32'(bus.ovf),  32'd0);
    rst = 1'b0;
    tick();

    // Single pulse: len 5, gap 2.
    bus.len = 8'd5; bus.gap = 8'd2; bus.retrig = 1'b0;
    run(12, 32'h1, qtr, btr, ptr, pmax, nrise);
    check("single_q",    qtr, 32'h1F);
    check("single_busy", btr, 32'h7F);
    check("single_pend", ptr, 32'h0);

    // Three queued requests: len 3, gap 2.
    bus.len = 8'd3; bus.gap = 8'd2;
    run(20, 32'h7, qtr, btr, ptr, pmax, nrise);
    check("queued_q",    qtr, 32'h1CE7);
    check("queued_busy", btr, 32'h7FFF);
    check("queued_pend", ptr, 32'h3FE);
    check("queued_pmax", 32'(pmax), 32'd2);

    // Retrigger: len 4, gap 0, second request three clocks later.
    bus.len = 8'd4; bus.gap = 8'd0; bus.retrig = 1'b1;
    run(12, 32'h9, qtr, btr, ptr, pmax, nrise);
    check("retrig_q",    qtr, 32'h7F);
    check("retrig_busy", btr, 32'h7F);
    check("retrig_pend", ptr, 32'h0);

    // Retrigger mode holds at most one request during GAP, without ovf.
    bus.len = 8'd2; bus.gap = 8'd3; bus.retrig = 1'b1;
    run(16, 32'h19, qtr, btr, ptr, pmax, nrise);
    check("rtsat_pmax", 32'(pmax),    32'd1);
    check("rtsat_ovf",  32'(bus.ovf), 32'd0);
    check("rtsat_nq",   32'(nrise),   32'd2);

    // len 0 behaves as a one-clock pulse.
    bus.len = 8'd0; bus.gap = 8'd0; bus.retrig = 1'b0;
    run(4, 32'h1, qtr, btr, ptr, pmax, nrise);
    check("len0_q",    qtr, 32'h1);
    check("len0_busy", btr, 32'h1);

    // gap 0 with one queued request merges into 2*Leff.
    bus.len = 8'd3; bus.gap = 8'd0;
    run(10, 32'h3, qtr, btr, ptr, pmax, nrise);
    check("merge_q",    qtr, 32'h3F);
    check("merge_busy", btr, 32'h3F);
    check("merge_pend", ptr, 32'h6);

    // Request on the terminal GAP clock with pend=1 keeps pend at 1.
    bus.len = 8'd2; bus.gap = 8'd2;
    run(16, 32'h13, qtr, btr, ptr, pmax, nrise);
    check("tgap_q",    qtr, 32'h333);
    check("tgap_busy", btr, 32'hFFF);
    check("tgap_pend", ptr, 32'hFE);

    // Overflow: five request clocks with a 2-bit queue.
    bus.len = 8'd20; bus.gap = 8'd1; bus.retrig = 1'b0;
    run(5, 32'h1F, qtr, btr, ptr, pmax, nrise);
    check("ovf_pend",  32'(bus.pend), 32'd3);
    check("ovf_flag",  32'(bus.ovf),  32'd1);
    run(95, 32'h0, qtr, btr, ptr, pmax, nrise);
    check("ovf_npulse", 32'(nrise + 1), 32'd4);
    check("ovf_sticky", 32'(bus.ovf),   32'd1);
    check("ovf_drain",  32'(bus.pend),  32'd0);
    check("ovf_idle",   32'(bus.busy),  32'd0);

    // Reset on the 3rd HIGH clock of a len 8 pulse with two queued.
    bus.len = 8'd8; bus.gap = 8'd1;
    bus.in = 1'b1; tick(); tick(); tick();
    check("rstm_pend_pre", 32'(bus.pend), 32'd2);
    check("rstm_q_pre",    32'(bus.q),    32'd1);
    rst = 1'b1;
    tick();
    check("rstm_q",    32'(bus.q),    32'd0);
    check("rstm_busy", 32'(bus.busy), 32'd0);
    check("rstm_pend", 32'(bus.pend), 32'd0);
    check("rstm_ovf",  32'(bus.ovf),  32'd0);
    tick();
    check("rstm_hold_q", 32'(bus.q), 32'd0);
    rst = 1'b0; bus.in = 1'b0;
    tick();
    check("rstm_after_q",    32'(bus.q),    32'd0);
    check("rstm_after_busy", 32'(bus.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
